// File: rtl/contrast_frame_stats.sv
// contrast_frame_stats: 1-deep AXI-Stream register slice with per-frame
// min / max / mean luminance statistics, published once per completed frame.
// The mean is computed by a serial restoring divider (sum / N, one bit per cycle).
module contrast_frame_stats #(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // pixel input stream
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    // registered copy of the input stream
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    // frame statistics
    output logic                  stat_valid,
    output logic [DATA_WIDTH-1:0] stat_min,
    output logic [DATA_WIDTH-1:0] stat_max,
    output logic [DATA_WIDTH-1:0] stat_mean,
    output logic                  stat_err
);

    localparam int N      = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int SUM_W  = DATA_WIDTH + $clog2(N);
    localparam int COL_W  = $clog2(FRAME_WIDTH + 1);
    localparam int LINE_W = $clog2(FRAME_HEIGHT + 1);
    localparam int CNT_W  = $clog2(SUM_W + 1);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(FRAME_WIDTH);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_HEIGHT - 1);
    localparam logic [SUM_W:0]    DIVISOR   = (SUM_W + 1)'(N);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SUM_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Stream register slice
    // ------------------------------------------------------------------
    logic accept;

    assign s_axis_tready = m_axis_tready | ~m_axis_tvalid;
    assign accept        = s_axis_tvalid & s_axis_tready;

    // Output register: loads whenever the slot is empty or being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (s_axis_tready) begin
            m_axis_tvalid <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                m_axis_tdata <= s_axis_tdata;
                m_axis_tlast <= s_axis_tlast;
                m_axis_tuser <= s_axis_tuser;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame accumulation
    // ------------------------------------------------------------------
    logic                  in_frame;
    logic [COL_W-1:0]      col;
    logic [LINE_W-1:0]     line;
    logic [DATA_WIDTH-1:0] min_acc;
    logic [DATA_WIDTH-1:0] max_acc;
    logic [SUM_W-1:0]      sum_acc;

    logic                  beat_act;
    logic                  line_bad;
    logic                  frame_done;
    logic                  err_nx;
    logic [COL_W-1:0]      col_nx;
    logic [LINE_W-1:0]     line_cur;
    logic [DATA_WIDTH-1:0] min_nx;
    logic [DATA_WIDTH-1:0] max_nx;
    logic [SUM_W-1:0]      sum_nx;

    // Next accumulator values for the beat being accepted; an SOF beat
    // restarts everything from that pixel, even mid-frame.
    always_comb begin
        beat_act = accept & (s_axis_tuser | in_frame);
        if (s_axis_tuser) begin
            col_nx   = COL_W'(1);
            line_cur = '0;
            min_nx   = s_axis_tdata;
            max_nx   = s_axis_tdata;
            sum_nx   = SUM_W'(s_axis_tdata);
        end else begin
            col_nx   = col + COL_W'(1);
            line_cur = line;
            min_nx   = (s_axis_tdata < min_acc) ? s_axis_tdata : min_acc;
            max_nx   = (s_axis_tdata > max_acc) ? s_axis_tdata : max_acc;
            sum_nx   = sum_acc + SUM_W'(s_axis_tdata);
        end
        line_bad   = s_axis_tlast ? (col_nx != COL_LAST) : (col_nx == COL_LAST);
        frame_done = beat_act & s_axis_tlast & ~line_bad & (line_cur == LINE_LAST);
        err_nx     = (accept & s_axis_tuser & in_frame) | (beat_act & line_bad);
    end

    // Framing state and running statistics; malformed lines drop the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame <= 1'b0;
            col      <= '0;
            line     <= '0;
            min_acc  <= '0;
            max_acc  <= '0;
            sum_acc  <= '0;
            stat_err <= 1'b0;
        end else begin
            stat_err <= err_nx;
            if (beat_act) begin
                min_acc <= min_nx;
                max_acc <= max_nx;
                sum_acc <= sum_nx;
                if (line_bad) begin
                    in_frame <= 1'b0;
                    col      <= '0;
                    line     <= '0;
                end else if (s_axis_tlast) begin
                    col <= '0;
                    if (line_cur == LINE_LAST) begin
                        in_frame <= 1'b0;
                        line     <= '0;
                    end else begin
                        in_frame <= 1'b1;
                        line     <= line_cur + LINE_W'(1);
                    end
                end else begin
                    in_frame <= 1'b1;
                    col      <= col_nx;
                    line     <= line_cur;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Divider FSM
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  div_cnt;
    logic [SUM_W-1:0]  rem;
    logic [SUM_W-1:0]  dq;
    logic [SUM_W:0]    rem_sh;
    logic              q_bit;
    logic [SUM_W-1:0]  rem_nx;
    logic [DATA_WIDTH-1:0] snap_min;
    logic [DATA_WIDTH-1:0] snap_max;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; a newly completed frame always (re)starts the division.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: state_nx = ST_IDLE;
            ST_DIV:  if (div_cnt == CNT_LAST) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        if (frame_done) begin
            state_nx = ST_DIV;
        end
    end

    // One restoring step: dq shifts the dividend out at the top and the
    // quotient in at the bottom, so after SUM_W steps dq holds sum / N.
    always_comb begin
        rem_sh = {rem, dq[SUM_W-1]};
        q_bit  = (rem_sh >= DIVISOR);
        rem_nx = q_bit ? SUM_W'(rem_sh - DIVISOR) : rem_sh[SUM_W-1:0];
    end

    assign stat_valid = (state == ST_DONE);

    // Divider datapath and published statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            rem       <= '0;
            dq        <= '0;
            snap_min  <= '0;
            snap_max  <= '0;
            stat_min  <= '0;
            stat_max  <= '0;
            stat_mean <= '0;
        end else if (frame_done) begin
            div_cnt  <= '0;
            rem      <= '0;
            dq       <= sum_nx;
            snap_min <= min_nx;
            snap_max <= max_nx;
        end else if (state == ST_DIV) begin
            div_cnt <= div_cnt + CNT_W'(1);
            rem     <= rem_nx;
            dq      <= {dq[SUM_W-2:0], q_bit};
            if (div_cnt == CNT_LAST) begin
                stat_min  <= snap_min;
                stat_max  <= snap_max;
                stat_mean <= DATA_WIDTH'({dq[SUM_W-2:0], q_bit});
            end
        end
    end

endmodule

// File: tb/tb_contrast_frame_stats.sv
// Bench for contrast_frame_stats: a 4x2 instance driven from a table of
// framed beat sequences with a stream scoreboard, plus a 40x25 instance for
// a large constant frame.
`timescale 1ns/1ps
module tb_contrast_frame_stats;

    localparam int SW_SMALL = 8 + 3;   // 8-bit pixels, N = 8
    localparam int SW_BIG   = 8 + 10;  // 8-bit pixels, N = 1000
    localparam int BIG_W    = 40;
    localparam int BIG_H    = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       s_valid, s_ready, s_last, s_user;
    logic [7:0] s_data;
    logic       m_valid, m_ready, m_last, m_user;
    logic [7:0] m_data;
    logic       st_valid, st_err;
    logic [7:0] st_min, st_max, st_mean;

    logic       b_s_valid, b_s_ready, b_s_last, b_s_user;
    logic [7:0] b_s_data;
    logic       b_m_valid, b_m_ready, b_m_last, b_m_user;
    logic [7:0] b_m_data;
    logic       b_st_valid, b_st_err;
    logic [7:0] b_st_min, b_st_max, b_st_mean;

    contrast_frame_stats #(.DATA_WIDTH(8), .FRAME_WIDTH(4), .FRAME_HEIGHT(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
        .s_axis_tlast(s_last), .s_axis_tuser(s_user),
        .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
        .m_axis_tlast(m_last), .m_axis_tuser(m_user),
        .stat_valid(st_valid), .stat_min(st_min), .stat_max(st_max),
        .stat_mean(st_mean), .stat_err(st_err)
    );

    contrast_frame_stats #(.DATA_WIDTH(8), .FRAME_WIDTH(BIG_W), .FRAME_HEIGHT(BIG_H)) u_big (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(b_s_valid), .s_axis_tready(b_s_ready), .s_axis_tdata(b_s_data),
        .s_axis_tlast(b_s_last), .s_axis_tuser(b_s_user),
        .m_axis_tvalid(b_m_valid), .m_axis_tready(b_m_ready), .m_axis_tdata(b_m_data),
        .m_axis_tlast(b_m_last), .m_axis_tuser(b_m_user),
        .stat_valid(b_st_valid), .stat_min(b_st_min), .stat_max(b_st_max),
        .stat_mean(b_st_mean), .stat_err(b_st_err)
    );

    typedef struct {
        logic [7:0] d;
        logic       u;
        logic       l;
    } beat_t;

    typedef struct {
        string      name;
        int         first;
        int         n;
        bit         bp;
        int         exp_valid;
        int         exp_err;
        logic [7:0] emin;
        logic [7:0] emax;
        logic [7:0] emean;
    } case_t;

    beat_t      beats[$];
    case_t      cases[$];
    logic [9:0] sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_valid, n_err, last_acc_cyc, lat;
    int b_n_valid, b_n_err, b_last_acc_cyc, b_lat, b_out_idx;
    logic [7:0] got_min, got_max, got_mean;
    logic [7:0] b_got_min, b_got_max, b_got_mean;
    bit bp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sampled on the falling edge: scoreboard both streams and record stats.
    task automatic monitor();
        logic [9:0] exp;
        if (!rst_n) begin
            sb.delete();
            return;
        end
        if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_extra: got beat %0h expected none", {m_user, m_last, m_data});
            end else begin
                exp = sb.pop_front();
                check("stream_beat", {22'd0, m_user, m_last, m_data}, {22'd0, exp});
            end
        end
        if (s_valid && s_ready) begin
            sb.push_back({s_user, s_last, s_data});
            if (s_last) last_acc_cyc = cyc;
        end
        if (st_valid) begin
            n_valid++;
            got_min  = st_min;
            got_max  = st_max;
            got_mean = st_mean;
            lat      = cyc - last_acc_cyc;
        end
        if (st_err) n_err++;

        if (b_m_valid && b_m_ready) begin
            check("big_stream_beat", {22'd0, b_m_user, b_m_last, b_m_data},
                  {22'd0, (b_out_idx == 0), ((b_out_idx % BIG_W) == BIG_W - 1), 8'd128});
            b_out_idx++;
        end
        if (b_s_valid && b_s_ready && b_s_last) b_last_acc_cyc = cyc;
        if (b_st_valid) begin
            b_n_valid++;
            b_got_min  = b_st_min;
            b_got_max  = b_st_max;
            b_got_mean = b_st_mean;
            b_lat      = cyc - b_last_acc_cyc;
        end
        if (b_st_err) b_n_err++;
    endtask

    task automatic cycle(output bit acc, output bit b_acc);
        @(negedge clk);
        acc   = s_valid & s_ready;
        b_acc = b_s_valid & b_s_ready;
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        m_ready = bp ? ~m_ready : 1'b1;
    endtask

    task automatic idle(input int k);
        bit a, b;
        for (int i = 0; i < k; i++) cycle(a, b);
    endtask

    task automatic send(input beat_t bt);
        bit a, b;
        bit done;
        done    = 1'b0;
        s_valid = 1'b1;
        s_data  = bt.d;
        s_user  = bt.u;
        s_last  = bt.l;
        for (int k = 0; k < 50 && !done; k++) begin
            cycle(a, b);
            done = a;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no handshake expected accept of %0d", bt.d);
        end
        s_valid = 1'b0;
        s_data  = '0;
        s_user  = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic add(input logic [7:0] d, input logic u, input logic l);
        beat_t bt;
        bt.d = d;
        bt.u = u;
        bt.l = l;
        beats.push_back(bt);
    endtask

    task automatic add_frame(input logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7);
        add(p0, 1'b1, 1'b0); add(p1, 1'b0, 1'b0); add(p2, 1'b0, 1'b0); add(p3, 1'b0, 1'b1);
        add(p4, 1'b0, 1'b0); add(p5, 1'b0, 1'b0); add(p6, 1'b0, 1'b0); add(p7, 1'b0, 1'b1);
    endtask

    task automatic add_case(input string name, input int first, input bit bpm, input int ev,
                            input int ee, input logic [7:0] mn, mx, me);
        case_t c;
        c.name = name; c.first = first; c.n = beats.size() - first; c.bp = bpm;
        c.exp_valid = ev; c.exp_err = ee; c.emin = mn; c.emax = mx; c.emean = me;
        cases.push_back(c);
    endtask

    task automatic run_frame(input int first, input int n);
        for (int i = 0; i < n; i++) send(beats[first + i]);
    endtask

    initial begin
        int f;
        bit a, b, done;

        rst_n = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_user = 1'b0; m_ready = 1'b1;
        b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0; b_s_user = 1'b0; b_m_ready = 1'b1;
        n_valid = 0; n_err = 0; last_acc_cyc = 0; lat = 0;
        b_n_valid = 0; b_n_err = 0; b_last_acc_cyc = 0; b_lat = 0; b_out_idx = 0;
        got_min = '0; got_max = '0; got_mean = '0;
        b_got_min = '0; b_got_max = '0; b_got_mean = '0;

        // ---- stimulus table ----
        f = beats.size();
        add(8'd1, 1'b0, 1'b0); add(8'd2, 1'b0, 1'b0); add(8'd3, 1'b0, 1'b1);
        add_case("no_sof", f, 1'b0, 0, 0, 8'd0, 8'd0, 8'd0);
        f = beats.size();
        add_frame(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd255);
        add_case("basic", f, 1'b0, 1, 0, 8'd10, 8'd255, 8'd66);
        f = beats.size();
        add_frame(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd255);
        add_case("backpressure", f, 1'b1, 1, 0, 8'd10, 8'd255, 8'd66);
        f = beats.size();
        add(8'd5, 1'b1, 1'b0); add(8'd6, 1'b0, 1'b0); add(8'd99, 1'b0, 1'b1);
        add_frame(8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7);
        add_case("short_line", f, 1'b0, 1, 1, 8'd7, 8'd7, 8'd7);
        f = beats.size();
        add(8'd9, 1'b1, 1'b0); add(8'd9, 1'b0, 1'b0); add(8'd9, 1'b0, 1'b0); add(8'd9, 1'b0, 1'b0);
        add_frame(8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3);
        add_case("long_line", f, 1'b0, 1, 1, 8'd3, 8'd3, 8'd3);
        f = beats.size();
        add(8'd200, 1'b1, 1'b0); add(8'd201, 1'b0, 1'b0); add(8'd202, 1'b0, 1'b0);
        add(8'd203, 1'b0, 1'b1); add(8'd204, 1'b0, 1'b0);
        add_frame(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        add_case("sof_restart", f, 1'b1, 1, 1, 8'd1, 8'd8, 8'd4);

        // ---- reset state ----
        idle(3);
        check("reset_m_tvalid", m_valid, 0);
        check("reset_stat_valid", st_valid, 0);
        check("reset_stat_err", st_err, 0);
        check("reset_stat_min", st_min, 0);
        check("reset_stat_max", st_max, 0);
        check("reset_stat_mean", st_mean, 0);
        check("reset_s_tready", s_ready, 1);
        rst_n = 1'b1;
        idle(2);

        // ---- table-driven frames ----
        foreach (cases[ci]) begin
            n_valid = 0;
            n_err   = 0;
            bp      = cases[ci].bp;
            run_frame(cases[ci].first, cases[ci].n);
            bp = 1'b0;
            idle(24);
            check({cases[ci].name, "_drained"}, sb.size(), 0);
            check({cases[ci].name, "_n_valid"}, n_valid, cases[ci].exp_valid);
            check({cases[ci].name, "_n_err"}, n_err, cases[ci].exp_err);
            if (cases[ci].exp_valid > 0) begin
                check({cases[ci].name, "_min"}, got_min, cases[ci].emin);
                check({cases[ci].name, "_max"}, got_max, cases[ci].emax);
                check({cases[ci].name, "_mean"}, got_mean, cases[ci].emean);
                check({cases[ci].name, "_latency_ok"}, (lat > 0 && lat <= SW_SMALL + 3), 1);
            end
        end

        // ---- reset during division ----
        f = beats.size();
        add_frame(8'd11, 8'd11, 8'd11, 8'd11, 8'd11, 8'd11, 8'd11, 8'd11);
        n_valid = 0;
        n_err   = 0;
        run_frame(f, 8);
        idle(3);
        rst_n = 1'b0;
        #1;
        check("divrst_m_tvalid", m_valid, 0);
        check("divrst_stat_valid", st_valid, 0);
        check("divrst_stat_min", st_min, 0);
        check("divrst_stat_max", st_max, 0);
        check("divrst_stat_mean", st_mean, 0);
        check("divrst_s_tready", s_ready, 1);
        idle(2);
        rst_n = 1'b1;
        idle(24);
        check("divrst_no_valid", n_valid, 0);
        check("divrst_mean_held", st_mean, 0);

        f = beats.size();
        add_frame(8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd14, 8'd16);
        run_frame(f, 8);
        idle(24);
        check("postrst_n_valid", n_valid, 1);
        check("postrst_min", got_min, 2);
        check("postrst_max", got_max, 16);
        check("postrst_mean", got_mean, 9);

        // ---- large constant frame on the 40x25 instance ----
        b_n_valid = 0;
        b_n_err   = 0;
        b_out_idx = 0;
        for (int i = 0; i < BIG_W * BIG_H; i++) begin
            b_s_valid = 1'b1;
            b_s_data  = 8'd128;
            b_s_user  = (i == 0);
            b_s_last  = ((i % BIG_W) == BIG_W - 1);
            done = 1'b0;
            for (int k = 0; k < 50 && !done; k++) begin
                cycle(a, b);
                done = b;
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL big_send_timeout: got no handshake expected accept of beat %0d", i);
            end
        end
        b_s_valid = 1'b0;
        b_s_user  = 1'b0;
        b_s_last  = 1'b0;
        idle(30);
        check("big_out_beats", b_out_idx, BIG_W * BIG_H);
        check("big_n_valid", b_n_valid, 1);
        check("big_n_err", b_n_err, 0);
        check("big_min", b_got_min, 128);
        check("big_max", b_got_max, 128);
        check("big_mean", b_got_mean, 128);
        check("big_latency_ok", (b_lat > 0 && b_lat <= SW_BIG + 3), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
